// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath word and fetch-entry types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;
  localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, redirect/halt control and decode-side queue head
interface fetch_queue_if
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          imemREN;
  word_t         imemaddr;
  logic          ihit;
  word_t         imemload;
  logic          redirect;
  word_t         redirect_pc;
  logic          halt;
  logic          deq;
  logic          valid;
  word_t         instr;
  word_t         instr_pc;
  word_t         npc;
  logic [CW-1:0] count;
  modport master (
    input  ihit, imemload, redirect, redirect_pc, halt, deq,
    output imemREN, imemaddr, valid, instr, instr_pc, npc, count
  );
  modport slave (
    output ihit, imemload, redirect, redirect_pc, halt, deq,
    input  imemREN, imemaddr, valid, instr, instr_pc, npc, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of fetch entries with flush; storage is not reset, only pointers
module fetch_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    do_push = push_i & !flush_i & (cnt_q != CW'(DEPTH));
    do_pop  = pop_i & !flush_i & (cnt_q != '0);
    rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
    wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
    cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  assign head_o  = mem_q[rd_q];
  assign valid_o = cnt_q != '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner issuing imem reads and buffering returned words for decode
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0,
  parameter int    DEPTH   = 4
) (
  input logic CLK,
  input logic nRST,
  fetch_queue_if.master fq
);
  localparam int CW = $clog2(DEPTH) + 1;
  word_t         pc_q, pc_d;
  fetch_entry_t  entry, head;
  logic          push, has;
  logic [CW-1:0] cnt;
  always_comb begin
    fq.imemREN = nRST & !fq.halt & !fq.redirect & (cnt < CW'(DEPTH));
    push       = fq.ihit & fq.imemREN;
    entry      = '{pc: pc_q, instr: fq.imemload};
    pc_d       = fq.redirect ? {fq.redirect_pc[31:2], 2'b00} : (push ? pc_q + PC_STEP : pc_q);
  end
  always_ff @(posedge CLK) begin
    if (!nRST) pc_q <= PC_INIT;
    else       pc_q <= pc_d;
  end
  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .CLK     (CLK),
    .nRST    (nRST),
    .push_i  (push),
    .pop_i   (fq.deq),
    .flush_i (fq.redirect),
    .din_i   (entry),
    .head_o  (head),
    .valid_o (has),
    .count_o (cnt)
  );
  // head fields read as zero when empty so stale storage never leaks out
  assign fq.imemaddr = pc_q;
  assign fq.valid    = has;
  assign fq.instr    = has ? head.instr : '0;
  assign fq.instr_pc = has ? head.pc : '0;
  assign fq.npc      = has ? head.pc + PC_STEP : '0;
  assign fq.count    = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus hand sequences for fetch_queue
module tb_fetch_queue;
  import cpu_types_pkg::*;
  typedef struct {
    logic n, ih, rd, h, dq;
    word_t rpc;
    logic e_ren, e_v;
    word_t e_addr, e_ipc;
    logic [2:0] e_cnt;
  } vec_t;
  logic CLK = 0;
  logic nRST;
  int checks = 0, errors = 0, row = 0;
  vec_t vecs[$];
  fetch_queue_if #(.DEPTH(4)) fq ();
  fetch_queue #(.PC_INIT(32'h100), .DEPTH(4)) dut (.CLK(CLK), .nRST(nRST), .fq(fq));
  always #5 CLK = ~CLK;
  function automatic word_t ld(input word_t p);
    return p ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask
  task automatic add(input logic n, ih, rd, input word_t rpc, input logic h, dq,
                     input logic ren, input word_t addr, input logic v, input word_t ipc, input logic [2:0] cnt);
    vec_t t;
    t.n = n; t.ih = ih; t.rd = rd; t.rpc = rpc; t.h = h; t.dq = dq;
    t.e_ren = ren; t.e_addr = addr; t.e_v = v; t.e_ipc = ipc; t.e_cnt = cnt;
    vecs.push_back(t);
  endtask
  initial begin
    int n;
    nRST = 0; fq.ihit = 0; fq.imemload = 0; fq.redirect = 0; fq.redirect_pc = 0; fq.halt = 0; fq.deq = 0;
    //  n ih rd rpc           h dq   ren addr          v ipc           cnt
    add(1, 1, 0, 0,            0, 0,  1, 32'h100,      0, 0,           0);
    add(1, 1, 0, 0,            0, 0,  1, 32'h104,      1, 32'h100,     1);
    add(1, 1, 0, 0,            0, 0,  1, 32'h108,      1, 32'h100,     2);
    add(1, 1, 0, 0,            0, 0,  1, 32'h10C,      1, 32'h100,     3);
    add(1, 1, 0, 0,            0, 0,  0, 32'h110,      1, 32'h100,     4);
    add(1, 1, 0, 0,            0, 1,  0, 32'h110,      1, 32'h100,     4);
    add(1, 1, 0, 0,            0, 1,  1, 32'h110,      1, 32'h104,     3);
    add(1, 1, 0, 0,            0, 1,  1, 32'h114,      1, 32'h108,     3);
    add(1, 1, 1, 32'h2003,     0, 1,  0, 32'h118,      1, 32'h10C,     3);
    add(1, 1, 0, 0,            0, 0,  1, 32'h2000,     0, 0,           0);
    add(1, 1, 0, 0,            0, 0,  1, 32'h2004,     1, 32'h2000,    1);
    add(1, 1, 0, 0,            1, 0,  0, 32'h2008,     1, 32'h2000,    2);
    add(1, 1, 0, 0,            1, 1,  0, 32'h2008,     1, 32'h2000,    2);
    add(1, 1, 0, 0,            1, 1,  0, 32'h2008,     1, 32'h2004,    1);
    add(1, 1, 0, 0,            1, 0,  0, 32'h2008,     0, 0,           0);
    add(1, 1, 0, 0,            0, 0,  1, 32'h2008,     0, 0,           0);
    add(1, 0, 0, 0,            0, 0,  1, 32'h200C,     1, 32'h2008,    1);
    add(1, 1, 1, 32'hFFFFFFFC, 0, 1,  0, 32'h200C,     1, 32'h2008,    1);
    add(1, 1, 0, 0,            0, 0,  1, 32'hFFFFFFFC, 0, 0,           0);
    add(1, 1, 0, 0,            0, 0,  1, 32'h0,        1, 32'hFFFFFFFC, 1);
    add(1, 0, 0, 0,            0, 0,  1, 32'h4,        1, 32'hFFFFFFFC, 2);
    add(1, 0, 0, 0,            0, 1,  1, 32'h4,        1, 32'hFFFFFFFC, 2);
    add(1, 1, 0, 0,            0, 0,  1, 32'h4,        1, 32'h0,       1);
    add(1, 1, 0, 0,            0, 0,  1, 32'h8,        1, 32'h0,       2);
    add(0, 1, 0, 0,            0, 0,  0, 32'hC,        1, 32'h0,       3);
    add(1, 0, 0, 0,            0, 1,  1, 32'h100,      0, 0,           0);
    add(1, 0, 0, 0,            0, 0,  1, 32'h100,      0, 0,           0);
    @(posedge CLK);
    foreach (vecs[i]) begin
      @(negedge CLK);
      row = i + 1;
      nRST = vecs[i].n; fq.ihit = vecs[i].ih; fq.redirect = vecs[i].rd; fq.redirect_pc = vecs[i].rpc;
      fq.halt = vecs[i].h; fq.deq = vecs[i].dq; fq.imemload = ld(vecs[i].e_addr);
      #1;
      chk("imemREN", 32'(fq.imemREN), 32'(vecs[i].e_ren));
      chk("imemaddr", fq.imemaddr, vecs[i].e_addr);
      chk("valid", 32'(fq.valid), 32'(vecs[i].e_v));
      chk("instr_pc", fq.instr_pc, vecs[i].e_ipc);
      chk("instr", fq.instr, vecs[i].e_v ? ld(vecs[i].e_ipc) : 32'h0);
      chk("npc", fq.npc, vecs[i].e_v ? vecs[i].e_ipc + 32'd4 : 32'h0);
      chk("count", 32'(fq.count), 32'(vecs[i].e_cnt));
    end
    row = 100;
    n = 0;
    while (fq.count != 3'd4 && n < 10) begin
      @(negedge CLK);
      nRST = 1; fq.ihit = 1; fq.deq = 0; fq.halt = 0; fq.redirect = 0;
      fq.imemload = ld(fq.imemaddr);
      @(posedge CLK);
      #1;
      n++;
    end
    @(negedge CLK);
    chk("fill_budget", 32'(fq.count == 3'd4), 32'd1);
    chk("fill_cycles", n, 4);
    chk("fill_ren", 32'(fq.imemREN), 32'd0);
    chk("fill_addr", fq.imemaddr, 32'h110);
    chk("fill_head_pc", fq.instr_pc, 32'h100);
    chk("fill_head_instr", fq.instr, ld(32'h100));
    row = 101;
    fq.halt = 1; fq.redirect = 1; fq.redirect_pc = 32'h3001;
    #1;
    chk("redir_ren", 32'(fq.imemREN), 32'd0);
    @(negedge CLK);
    fq.redirect = 0;
    #1;
    chk("redir_halt_addr", fq.imemaddr, 32'h3000);
    chk("redir_halt_ren", 32'(fq.imemREN), 32'd0);
    chk("redir_halt_cnt", 32'(fq.count), 32'd0);
    @(negedge CLK);
    fq.halt = 0;
    #1;
    chk("resume_ren", 32'(fq.imemREN), 32'd1);
    chk("resume_addr", fq.imemaddr, 32'h3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
